// File: rtl/perf_event_counters.sv
// Per-channel event counters plus a cycle counter, frozen on processor halt,
// with sticky overflow flags and a registered one-cycle read port.
module perf_event_counters #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32,
  parameter int SAT    = 1,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              halt,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic [NUM_CH:0]   ovf,
  output logic              frozen
);

  // state  | meaning
  // RUN    | counters advance on enabled cycles
  // FROZEN | halt seen; all counts held until clear
  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_e;

  state_e                       state_q, state_d;
  logic [NUM_CH:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH:0]              ovf_q, ovf_d;
  logic [NUM_CH:0]              inc;
  logic                         rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]             rd_data_q, rd_data_d;
  logic                         rd_err_q, rd_err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    inc     = '0;
    if (clear) begin
      state_d = RUN;
      cnt_d   = '0;
      ovf_d   = '0;
    end else if (state_q == RUN) begin
      // the halting cycle itself still counts
      if (halt) state_d = FROZEN;
      if (en) inc = {1'b1, event_i};
      for (int k = 0; k <= NUM_CH; k++) begin
        if (inc[k]) begin
          if (&cnt_q[k]) begin
            ovf_d[k] = 1'b1;
            if (SAT == 0) cnt_d[k] = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Reads return the post-update value so they agree with the counters one cycle later.
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    if (rd_req) begin
      rd_err_d  = (rd_sel > SEL_W'(NUM_CH));
      rd_data_d = '0;
      for (int k = 0; k <= NUM_CH; k++) begin
        if (rd_sel == SEL_W'(k)) rd_data_d = cnt_d[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign ovf      = ovf_q;
  assign frozen   = (state_q == FROZEN);

endmodule
